active_list_commit: RTL and testbench
=====================================

Name: active_list_commit

Overview:
Completion tracker and in-order retirement unit. It sits directly downstream of the writeback stage.
- Consumes per-lane writeback control packets of the form {activeListIndex, writebackFlags}.
- Consumes the load-violation packet from the writeback stage.
- Allocates entries at dispatch and retires up to two instructions per cycle in program order.
- Raises a pipeline flush when the head entry carries an exception or a load violation.

Parameters:
AL_DEPTH, 32, active-list entries; power of two.
AL_LOG, 5, log2(AL_DEPTH).
WB_LANES, 4, writeback lanes (ctrlFU0..3).
WB_FLAGS, 2, writeback flag width. Bit0 = control-transfer (informational). Bit1 = exception.
PHY_LOG, 7, physical register tag width.
LOG_REG_LOG, 5, logical register index width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dispatchValid_i  in  1  allocate one entry this cycle
dispatchLogDest_i  in  LOG_REG_LOG  logical destination of the dispatched instruction
dispatchPhyDest_i  in  PHY_LOG  physical destination of the dispatched instruction
dispatchIndex_o  out  AL_LOG  tail index the dispatched instruction receives (combinational)
alFull_o  out  1  no free entry; dispatch is ignored (combinational)
wbValid_i  in  WB_LANES  per-lane writeback valid
wbPacket_i  in  WB_LANES*(AL_LOG+WB_FLAGS)  lane k = {index, flags} at slice k
ldViolation_i  in  AL_LOG+1  {valid, index} load-ordering violation
commitValid_o  out  2  retire slot valid; slot1 is valid only if slot0 is valid
commitLogDest_o  out  2*LOG_REG_LOG  retired logical destinations
commitPhyDest_o  out  2*PHY_LOG  retired physical tags, to free-list/AMT
flush_o  out  1  one-cycle pulse: head needs recovery
flushIndex_o  out  AL_LOG  head index that caused the flush
alCount_o  out  AL_LOG+1  current occupancy

Behaviour:
- State: head and tail pointers, each AL_LOG+1 bits (wrap bit + index); count = tail - head.
- Per entry: done, exc, viol, logDest, phyDest.
- Reset (synchronous): head = tail = 0; all done/exc/viol = 0; commitValid_o = 0; flush_o = 0; flushIndex_o = 0. alCount_o = 0 and alFull_o = 0 the following cycle.
- Dispatch:
  - Accepted iff dispatchValid_i & ~alFull_o.
  - Writes payload at tail[AL_LOG-1:0] and clears done/exc/viol of that entry; tail++ wraps naturally.
  - alFull_o = (count == AL_DEPTH).
- Writeback:
  - Each valid lane sets done[index] and ORs flags into exc.
  - A lane naming an index outside [head, tail) is ignored.
  - Several lanes on different indices in one cycle are all applied.
- Load violation: ldViolation_i valid sets viol[index]. It does not need to set done.
- Latency: writeback at cycle N makes the entry retirable at cycle N+1; commit outputs are registered at N+1.
- Commit (evaluated on registered state):
  - Slot0 retires head if count >= 1, done, ~exc and ~viol.
  - Slot1 retires head+1 if slot0 retires, count >= 2, done, ~exc and ~viol.
  - head advances by the number retired; count updates as +dispatch - retired in the same cycle.
- Flush:
  - Condition: count >= 1 and head has (done & exc) or viol.
  - flush_o = 1 next cycle, flushIndex_o = head index, no commit in that cycle.
  - On the edge where flush_o is registered, the whole list is cleared (head = tail = 0, all bits 0); a dispatch in that cycle is dropped.
  - flush_o lasts exactly one cycle.
- Simultaneous events:
  - Writeback to an entry retiring in the same cycle is harmless.
  - Dispatch into the slot freed by this cycle's commit is not allowed: full is computed before commit.
- Reset mid-operation overrides dispatch, writeback and flush.

Optional Feature:
AL_WB_CHECK_EN:
- When defined, adds output wbError_o (1 bit, registered, sticky until reset). It sets when any of the following occurs:
  - a writeback lane targets an index outside [head, tail);
  - a writeback lane targets an entry already done;
  - two lanes target the same index in one cycle.
- When undefined, the port and its logic are absent and such writebacks are silently ignored or merged.

Decomposition:
- Shared package holds:
  - AL_DEPTH, AL_LOG, WB_FLAGS;
  - flag bit positions WB_FLAG_CTRL = 0 and WB_FLAG_EXC = 1;
  - an entry typedef {logDest, phyDest};
  - the writeback packet typedef {index, flags}.
- One sub-module, al_payload_ram: AL_DEPTH x (LOG_REG_LOG+PHY_LOG), one write port and two async read ports at head and head+1.

Test Plan:
- Dispatch 3 (phy 10, 11, 12), writeback indices 1 then 0 -> no commit after idx1 wb; next cycle after idx0 wb, commitValid = 2'b11 with phy 10, 11.
- Dispatch 32 with no writeback -> alFull_o = 1, alCount_o = 32, 33rd dispatch ignored, dispatchIndex_o = 0 after wrap.
- Head at idx 30, dispatch/complete through idx 1 -> in-order commits across wrap; alCount_o returns to 0.
- Writeback idx 0 with flags = 2'b10 -> flush_o pulses 1 cycle, flushIndex_o = 0, commitValid = 0, alCount_o = 0 the following cycle.
- ldViolation_i = {1, idx2} with idx0..2 done -> idx0/1 commit, next cycle flush_o with flushIndex_o = 2.
- With AL_WB_CHECK_EN, writeback to empty slot 5 -> wbError_o = 1 and stays high until reset.

Source files
------------

// File: rtl/active_list_commit_pkg.sv
// Shared types and constants for the active list: sizes, writeback flag positions,
// the per-entry payload and the writeback packet layout.
package active_list_commit_pkg;

    localparam int AL_DEPTH    = 32;
    localparam int AL_LOG      = 5;
    localparam int WB_LANES    = 4;
    localparam int WB_FLAGS    = 2;
    localparam int PHY_LOG     = 7;
    localparam int LOG_REG_LOG = 5;

    localparam int WB_FLAG_CTRL = 0;
    localparam int WB_FLAG_EXC  = 1;

    localparam int PKT_W   = AL_LOG + WB_FLAGS;
    localparam int ENTRY_W = LOG_REG_LOG + PHY_LOG;

    typedef struct packed {
        logic [LOG_REG_LOG-1:0] log_dest;
        logic [PHY_LOG-1:0]     phy_dest;
    } al_entry_t;

    typedef struct packed {
        logic [AL_LOG-1:0]   index;
        logic [WB_FLAGS-1:0] flags;
    } wb_packet_t;

    // True when idx lies in the occupied window [head, head + count).
    function automatic logic al_in_range(input logic [AL_LOG-1:0] idx,
                                         input logic [AL_LOG-1:0] head_idx,
                                         input logic [AL_LOG:0]   count);
        logic [AL_LOG-1:0] offset;
        offset = idx - head_idx;
        return {1'b0, offset} < count;
    endfunction

endpackage

// File: rtl/active_list_commit_al_payload_ram.sv
// Active-list payload storage: one write port at the tail, two asynchronous
// read ports at head and head+1 for dual retirement.
module al_payload_ram
    import active_list_commit_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [AL_LOG-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AL_LOG-1:0]  raddr0,
    input  logic [AL_LOG-1:0]  raddr1,
    output logic [ENTRY_W-1:0] rdata0,
    output logic [ENTRY_W-1:0] rdata1
);

    logic [ENTRY_W-1:0] mem [AL_DEPTH];

    // NOTE: payload is not reset; an entry is only read after dispatch has written it.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/active_list_commit.sv
// Active list: tracks writeback completion and retires up to two instructions per
// cycle in order, flushing on a faulting head. Optional macro: AL_WB_CHECK_EN.
module active_list_commit
    import active_list_commit_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                dispatchValid_i,
    input  logic [LOG_REG_LOG-1:0]              dispatchLogDest_i,
    input  logic [PHY_LOG-1:0]                  dispatchPhyDest_i,
    output logic [AL_LOG-1:0]                   dispatchIndex_o,
    output logic                                alFull_o,
    input  logic [WB_LANES-1:0]                 wbValid_i,
    input  logic [WB_LANES*PKT_W-1:0]           wbPacket_i,
    input  logic [AL_LOG:0]                     ldViolation_i,
    output logic [1:0]                          commitValid_o,
    output logic [2*LOG_REG_LOG-1:0]            commitLogDest_o,
    output logic [2*PHY_LOG-1:0]                commitPhyDest_o,
    output logic                                flush_o,
    output logic [AL_LOG-1:0]                   flushIndex_o,
    output logic [AL_LOG:0]                     alCount_o
`ifdef AL_WB_CHECK_EN
    ,
    output logic                                wbError_o
`endif
);

    logic [AL_LOG:0]     head, tail, count, retire_n;
    logic [AL_LOG-1:0]   head_idx, head1_idx, tail_idx;
    logic [AL_DEPTH-1:0] done, exc, viol;
    logic                dispatch_ok, slot0, slot1, flush_cond;
    logic                ctrl_flags_unused;
    logic [WB_LANES-1:0] lane_in_range;
    wb_packet_t          pkt [WB_LANES];
    al_entry_t           rd0, rd1, wr_entry;

    assign head_idx  = head[AL_LOG-1:0];
    assign head1_idx = head_idx + 1'b1;
    assign tail_idx  = tail[AL_LOG-1:0];
    assign count     = tail - head;

    assign alFull_o        = (count == (AL_LOG+1)'(AL_DEPTH));
    assign alCount_o       = count;
    assign dispatchIndex_o = tail_idx;
    assign dispatch_ok     = dispatchValid_i & ~alFull_o;

    assign wr_entry.log_dest = dispatchLogDest_i;
    assign wr_entry.phy_dest = dispatchPhyDest_i;

    al_payload_ram u_payload (
        .clk    (clk),
        .we     (dispatch_ok),
        .waddr  (tail_idx),
        .wdata  (wr_entry),
        .raddr0 (head_idx),
        .raddr1 (head1_idx),
        .rdata0 (rd0),
        .rdata1 (rd1)
    );

    // NOTE: every variable gets a default first so the block never infers a latch.
    always_comb begin
        ctrl_flags_unused = 1'b0;
        lane_in_range     = '0;
        for (int k = 0; k < WB_LANES; k++) begin
            pkt[k]            = wb_packet_t'(wbPacket_i[k*PKT_W +: PKT_W]);
            lane_in_range[k]  = al_in_range(pkt[k].index, head_idx, count);
            ctrl_flags_unused = ctrl_flags_unused ^ pkt[k].flags[WB_FLAG_CTRL];
        end
    end

    // Retirement and flush are decided purely from registered state.
    assign slot0 = (count != '0) & done[head_idx] & ~exc[head_idx] & ~viol[head_idx];
    assign slot1 = slot0 & (count >= (AL_LOG+1)'(2))
                 & done[head1_idx] & ~exc[head1_idx] & ~viol[head1_idx];
    assign flush_cond = (count != '0)
                      & ((done[head_idx] & exc[head_idx]) | viol[head_idx]);
    assign retire_n = {{AL_LOG{1'b0}}, slot0} + {{AL_LOG{1'b0}}, slot1};

    // NOTE: non-blocking updates so every lane and the commit logic see pre-edge state.
    always_ff @(posedge clk) begin
        if (reset) begin
            head            <= '0;
            tail            <= '0;
            done            <= '0;
            exc             <= '0;
            viol            <= '0;
            commitValid_o   <= '0;
            commitLogDest_o <= '0;
            commitPhyDest_o <= '0;
            flush_o         <= 1'b0;
            flushIndex_o    <= '0;
        end else if (flush_cond) begin
            // Recovery empties the list; same-cycle dispatch and writeback are dropped.
            head          <= '0;
            tail          <= '0;
            done          <= '0;
            exc           <= '0;
            viol          <= '0;
            commitValid_o <= '0;
            flush_o       <= 1'b1;
            flushIndex_o  <= head_idx;
        end else begin
            flush_o         <= 1'b0;
            commitValid_o   <= {slot1, slot0};
            commitLogDest_o <= {rd1.log_dest, rd0.log_dest};
            commitPhyDest_o <= {rd1.phy_dest, rd0.phy_dest};
            head            <= head + retire_n;
            for (int k = 0; k < WB_LANES; k++) begin
                if (wbValid_i[k] && lane_in_range[k]) begin
                    done[pkt[k].index] <= 1'b1;
                    exc[pkt[k].index]  <= exc[pkt[k].index] | pkt[k].flags[WB_FLAG_EXC];
                end
            end
            if (ldViolation_i[AL_LOG]) viol[ldViolation_i[AL_LOG-1:0]] <= 1'b1;
            if (dispatch_ok) begin
                tail           <= tail + 1'b1;
                done[tail_idx] <= 1'b0;
                exc[tail_idx]  <= 1'b0;
                viol[tail_idx] <= 1'b0;
            end
        end
    end

`ifdef AL_WB_CHECK_EN
    logic wb_err_now;

    always_comb begin
        wb_err_now = 1'b0;
        for (int k = 0; k < WB_LANES; k++) begin
            if (wbValid_i[k]) begin
                if (!lane_in_range[k] || done[pkt[k].index]) wb_err_now = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (wbValid_i[j] && pkt[j].index == pkt[k].index) wb_err_now = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)           wbError_o <= 1'b0;
        else if (wb_err_now) wbError_o <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_active_list_commit.sv
// Directed self-checking bench for active_list_commit: in-order dual commit, full
// list, wrap-around, exception and load-violation flush, optional writeback checks.
module tb_active_list_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatchValid_i;
    logic [4:0]  dispatchLogDest_i;
    logic [6:0]  dispatchPhyDest_i;
    logic [4:0]  dispatchIndex_o;
    logic        alFull_o;
    logic [3:0]  wbValid_i;
    logic [27:0] wbPacket_i;
    logic [5:0]  ldViolation_i;
    logic [1:0]  commitValid_o;
    logic [9:0]  commitLogDest_o;
    logic [13:0] commitPhyDest_o;
    logic        flush_o;
    logic [4:0]  flushIndex_o;
    logic [5:0]  alCount_o;
`ifdef AL_WB_CHECK_EN
    logic        wbError_o;
`endif

    int checks   = 0;
    int failures = 0;

    active_list_commit dut (
        .clk               (clk),
        .reset             (reset),
        .dispatchValid_i   (dispatchValid_i),
        .dispatchLogDest_i (dispatchLogDest_i),
        .dispatchPhyDest_i (dispatchPhyDest_i),
        .dispatchIndex_o   (dispatchIndex_o),
        .alFull_o          (alFull_o),
        .wbValid_i         (wbValid_i),
        .wbPacket_i        (wbPacket_i),
        .ldViolation_i     (ldViolation_i),
        .commitValid_o     (commitValid_o),
        .commitLogDest_o   (commitLogDest_o),
        .commitPhyDest_o   (commitPhyDest_o),
        .flush_o           (flush_o),
        .flushIndex_o      (flushIndex_o),
        .alCount_o         (alCount_o)
`ifdef AL_WB_CHECK_EN
        ,
        .wbError_o         (wbError_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic dispatch(input logic [4:0] ld, input logic [6:0] pd);
        dispatchValid_i   = 1'b1;
        dispatchLogDest_i = ld;
        dispatchPhyDest_i = pd;
        step();
        dispatchValid_i   = 1'b0;
    endtask

    task automatic set_lane(input int k, input logic [4:0] idx, input logic [1:0] flags);
        wbValid_i[k]            = 1'b1;
        wbPacket_i[k*7 +: 7]    = {idx, flags};
    endtask

    task automatic clear_wb();
        wbValid_i  = '0;
        wbPacket_i = '0;
    endtask

    initial begin
        reset = 1'b1;
        dispatchValid_i = 1'b0;
        dispatchLogDest_i = '0;
        dispatchPhyDest_i = '0;
        wbValid_i = '0;
        wbPacket_i = '0;
        ldViolation_i = '0;
        step();
        step();
        check("rst_count", 32'(alCount_o), 32'd0);
        check("rst_full", 32'(alFull_o), 32'd0);
        check("rst_commit", 32'(commitValid_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_flush_idx", 32'(flushIndex_o), 32'd0);
        check("rst_disp_idx", 32'(dispatchIndex_o), 32'd0);
        reset = 1'b0;

        // Out-of-order completion, in-order dual retirement.
        dispatch(5'd1, 7'd10);
        dispatch(5'd2, 7'd11);
        dispatch(5'd3, 7'd12);
        check("t1_count3", 32'(alCount_o), 32'd3);
        set_lane(0, 5'd1, 2'b00);
        step();
        clear_wb();
        check("t1_no_commit_idx1", 32'(commitValid_o), 32'd0);
        set_lane(2, 5'd0, 2'b01);
        step();
        clear_wb();
        check("t1_no_commit_yet", 32'(commitValid_o), 32'd0);
        step();
        check("t1_commit_valid", 32'(commitValid_o), 32'b11);
        check("t1_commit_phy", 32'(commitPhyDest_o), 32'({7'd11, 7'd10}));
        check("t1_commit_log", 32'(commitLogDest_o), 32'({5'd2, 5'd1}));
        check("t1_count1", 32'(alCount_o), 32'd1);
        step();
        check("t1_idle", 32'(commitValid_o), 32'd0);
        set_lane(1, 5'd2, 2'b00);
        step();
        clear_wb();
        step();
        check("t1_last_valid", 32'(commitValid_o), 32'b01);
        check("t1_last_phy", 32'(commitPhyDest_o[6:0]), 32'd12);
        check("t1_empty", 32'(alCount_o), 32'd0);

        // Fill the list, overflow attempt, then drain across the wrap.
        do_reset();
        for (int i = 0; i < 32; i++) dispatch(5'(i), 7'(20 + i));
        check("t2_full", 32'(alFull_o), 32'd1);
        check("t2_count32", 32'(alCount_o), 32'd32);
        check("t2_disp_idx_wrap", 32'(dispatchIndex_o), 32'd0);
        dispatch(5'd31, 7'd99);
        check("t2_overflow_count", 32'(alCount_o), 32'd32);
        check("t2_overflow_idx", 32'(dispatchIndex_o), 32'd0);
        set_lane(0, 5'd0, 2'b00);
        set_lane(1, 5'd1, 2'b00);
        step();
        clear_wb();
        step();
        check("t2_commit_valid", 32'(commitValid_o), 32'b11);
        check("t2_commit_phy", 32'(commitPhyDest_o), 32'({7'd21, 7'd20}));
        check("t2_not_full", 32'(alFull_o), 32'd0);
        for (int c = 0; c < 7; c++) begin
            for (int k = 0; k < 4; k++) set_lane(k, 5'(2 + 4*c + k), 2'b00);
            step();
            clear_wb();
        end
        repeat (20) step();
        check("t3_count2", 32'(alCount_o), 32'd2);
        dispatch(5'd7, 7'd40);
        dispatch(5'd8, 7'd41);
        check("t3_count4", 32'(alCount_o), 32'd4);
        set_lane(0, 5'd30, 2'b00);
        set_lane(1, 5'd31, 2'b00);
        set_lane(2, 5'd0, 2'b00);
        set_lane(3, 5'd1, 2'b00);
        step();
        clear_wb();
        step();
        check("t3_wrap_valid_a", 32'(commitValid_o), 32'b11);
        check("t3_wrap_phy_a", 32'(commitPhyDest_o), 32'({7'd51, 7'd50}));
        check("t3_count_a", 32'(alCount_o), 32'd2);
        step();
        check("t3_wrap_valid_b", 32'(commitValid_o), 32'b11);
        check("t3_wrap_phy_b", 32'(commitPhyDest_o), 32'({7'd41, 7'd40}));
        check("t3_count_b", 32'(alCount_o), 32'd0);

        // Exception at head: one-cycle flush, dispatch in the flush cycle dropped.
        do_reset();
        dispatch(5'd4, 7'd60);
        dispatch(5'd5, 7'd61);
        set_lane(0, 5'd0, 2'b10);
        step();
        clear_wb();
        check("t4_pre_flush", 32'(flush_o), 32'd0);
        dispatchValid_i   = 1'b1;
        dispatchPhyDest_i = 7'd70;
        step();
        dispatchValid_i = 1'b0;
        check("t4_flush", 32'(flush_o), 32'd1);
        check("t4_flush_idx", 32'(flushIndex_o), 32'd0);
        check("t4_no_commit", 32'(commitValid_o), 32'd0);
        check("t4_cleared", 32'(alCount_o), 32'd0);
        step();
        check("t4_flush_pulse", 32'(flush_o), 32'd0);
        check("t4_still_empty", 32'(alCount_o), 32'd0);

        // Load violation on idx2: idx0/1 retire, then flush at idx2.
        do_reset();
        dispatch(5'd1, 7'd80);
        dispatch(5'd2, 7'd81);
        dispatch(5'd3, 7'd82);
        set_lane(0, 5'd0, 2'b00);
        set_lane(1, 5'd1, 2'b00);
        set_lane(2, 5'd2, 2'b00);
        ldViolation_i = {1'b1, 5'd2};
        step();
        clear_wb();
        ldViolation_i = '0;
        step();
        check("t5_commit_valid", 32'(commitValid_o), 32'b11);
        check("t5_commit_phy", 32'(commitPhyDest_o), 32'({7'd81, 7'd80}));
        check("t5_no_flush_yet", 32'(flush_o), 32'd0);
        step();
        check("t5_flush", 32'(flush_o), 32'd1);
        check("t5_flush_idx", 32'(flushIndex_o), 32'd2);
        check("t5_no_commit", 32'(commitValid_o), 32'd0);
        check("t5_cleared", 32'(alCount_o), 32'd0);

`ifdef AL_WB_CHECK_EN
        do_reset();
        check("t6_err_clear", 32'(wbError_o), 32'd0);
        set_lane(0, 5'd5, 2'b00);
        step();
        clear_wb();
        check("t6_err_set", 32'(wbError_o), 32'd1);
        repeat (3) step();
        check("t6_err_sticky", 32'(wbError_o), 32'd1);
        do_reset();
        check("t6_err_reset", 32'(wbError_o), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
